i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Audio playback serializer. Accepts stereo PCM sample pairs from a fabric-side producer over a valid/ready handshake, buffers them, and shifts them out on the codec DACDAT pin in I2S format.
- Runs as an I2S slave: the codec drives BCLK and DACLRCK, which this block samples with the system clock.
- Sits beside the audio codec conduit (ADCDAT/ADCLRCK/BCLK/DACDAT/DACLRCK) and is the transmit counterpart of the ADC capture path.

Parameters:
- DATA_W, 16, bits per channel word.
- FIFO_DEPTH, 4, number of stereo pairs buffered; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the BCLK/DACLRCK synchronizers.

Ports:
- clk  in  1  system clock, at least 4x BCLK.
- reset_n  in  1  synchronous, active-low reset.
- sample_left  in  DATA_W  left PCM word, two's complement.
- sample_right  in  DATA_W  right PCM word.
- sample_valid  in  1  producer offers a pair.
- sample_ready  out  1  block accepts a pair this cycle; equals FIFO not full.
- bclk  in  1  codec bit clock, asynchronous.
- daclrck  in  1  codec DAC frame clock, asynchronous; 0 = left channel, 1 = right channel.
- dacdat  out  1  serial data to the codec.
- underrun  out  1  one-clk pulse when a left slot starts with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently held.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n). All state updates on the rising edge of clk.
- Reset values: dacdat=0, underrun=0, fifo_level=0, sample_ready=0 during reset and 1 on the first cycle after release. FIFO is emptied, synchronizers are cleared, FSM goes to ALIGN.
- Synchronizers: bclk and daclrck each pass through SYNC_STAGES flops.
  - bfall = synced bclk was 1 last cycle and is 0 now. All serial actions occur only on cycles where bfall=1.
  - lr_q = daclrck value captured at the previous bfall.
- Write side: a pair is pushed when sample_valid && sample_ready. sample_left goes to the upper half of the entry, sample_right to the lower half. The producer must hold the pair until it is accepted.
- FSM states: ALIGN, DELAY, SHIFT, PAD.
  - ALIGN: dacdat=0. Leave only on a bfall where synced daclrck=0 and lr_q=1 (falling LRCK edge, start of the left slot), then go to DELAY. Partial frames after reset are discarded.
  - Any state, on a bfall where daclrck differs from lr_q, go to DELAY and record ch = daclrck. This I2S edge always restarts the slot, even mid-word.
  - DELAY: the I2S one-BCLK delay. On the next bfall:
    - Load the shift register and drive its MSB on dacdat, then go to SHIFT with bitcnt = DATA_W-1.
    - If ch=0: pop the FIFO into a hold register and load the left word. If the FIFO is empty, load 0, hold right=0, and pulse underrun for exactly 1 clk.
    - If ch=1: load the hold register's right word. No pop.
  - SHIFT: each bfall shifts left and drives the next bit, decrementing bitcnt. When bitcnt reaches 0, go to PAD.
  - PAD: dacdat=0 until the next LRCK edge. Covers slots longer than DATA_W BCLKs.
- Slot too short: if an LRCK edge arrives before all DATA_W bits are sent, the remaining bits are dropped without error.
- Simultaneous push and pop in one clk: fifo_level is unchanged. A push while full is impossible because sample_ready=0. A pop while empty produces the underrun behaviour above.
- Pointers: wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH.
- Reset mid-word: dacdat drops to 0 on the next clk and the FSM returns to ALIGN.

Decomposition:
- Shared package i2s_pkg: DATA_W default constant, FSM state enum (ALIGN, DELAY, SHIFT, PAD), LEFT/RIGHT channel constants.
- One sub-module, i2s_pair_fifo: synchronous FIFO, width 2*DATA_W, depth FIFO_DEPTH, with push, pop, full, empty and level outputs, and a synchronous active-low reset.
- The top module holds the synchronizers, edge detect, FSM, shift register and hold register.

Test Plan:
- Reset then idle: reset_n=0 for 5 clks, then 1 → dacdat=0, fifo_level=0, sample_ready=1, underrun=0. BCLK toggling with constant LRCK keeps the FSM in ALIGN.
- Single frame, clk=50 MHz, BCLK=3.125 MHz, 32 BCLK per slot: push L=16'hA5C3, R=16'h0F01, then start LRCK → on the BCLK after the LRCK fall the bits are 1010_0101_1100_0011 MSB-first followed by 16 zeros. After the LRCK rise, one BCLK later, 0000_1111_0000_0001. Exactly 1 pop.
- Underrun: FIFO empty at a left slot start → underrun high for exactly 1 clk, 32 zero bits left and right. Then push 16'h8000/16'h7FFF → the next frame carries those words.
- Backpressure: hold valid high with FIFO_DEPTH=4 and no BCLK → 4 pairs accepted, sample_ready=0, fifo_level=4. Start BCLK/LRCK → pairs emerge in order, fifo_level decrements once per frame. Push and pop in the same clk leaves fifo_level unchanged.
- Short slot: 12 BCLK per channel, word 16'hFFFF → 11 ones in the slot (1 delay + 11 bits), then the next slot restarts with the correct MSB and no lockup.
- Reset mid-SHIFT: assert reset_n=0 at bit 7 of a left word → dacdat=0 the next clk and FIFO cleared. After release, output stays 0 until a fresh LRCK falling edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S DAC transmit path: word width default,
// serializer state encoding and channel codes carried on DACLRCK.
package i2s_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } tx_state_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_pair_fifo.sv
// Synchronous first-word-fall-through FIFO holding stereo sample pairs.
// Push while full and pop while empty are ignored.
module i2s_pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(1'b0);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == LVL_ZERO);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S slave transmitter: buffers stereo pairs and serializes them MSB-first
// on DACDAT, one BCLK after each DACLRCK edge, timed by codec-driven clocks.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             sample_left,
    input  logic [DATA_W-1:0]             sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          bclk,
    input  logic                          daclrck,
    output logic                          dacdat,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    logic [SYNC_STAGES-1:0] bclk_sync_r;
    logic [SYNC_STAGES-1:0] lrck_sync_r;
    logic                   bclk_s;
    logic                   lrck_s;
    logic                   bclk_d_r;
    logic                   bfall_s;
    logic                   lr_q_r;
    logic                   lr_edge_s;

    tx_state_t              state_r;
    logic                   ch_r;
    logic [DATA_W-1:0]      shreg_r;
    logic [DATA_W-1:0]      hold_right_r;
    logic [CNT_W-1:0]       bitcnt_r;
    logic                   dacdat_r;
    logic                   underrun_r;
    logic                   ready_en_r;

    logic                   push_s;
    logic                   pop_s;
    logic [2*DATA_W-1:0]    fifo_rdata_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    assign bclk_s       = bclk_sync_r[SYNC_STAGES-1];
    assign lrck_s       = lrck_sync_r[SYNC_STAGES-1];
    assign bfall_s      = bclk_d_r & ~bclk_s;
    assign lr_edge_s    = lrck_s ^ lr_q_r;

    assign sample_ready = ready_en_r & ~fifo_full_s;
    assign push_s       = sample_valid & sample_ready;
    // Pop only on the left-slot load; an empty FIFO turns into an underrun instead.
    assign pop_s        = bfall_s & (state_r == DELAY) & ~lr_edge_s & (ch_r == LEFT) & ~fifo_empty_s;

    assign dacdat       = dacdat_r;
    assign underrun     = underrun_r;

    i2s_pair_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .wdata   ({sample_left, sample_right}),
        .pop     (pop_s),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    // Bring the codec clocks into the clk domain and hold off ready until reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_sync_r <= {SYNC_STAGES{1'b0}};
            lrck_sync_r <= {SYNC_STAGES{1'b0}};
            bclk_d_r    <= 1'b0;
            ready_en_r  <= 1'b0;
        end else begin
            bclk_sync_r <= (bclk_sync_r << 1) | SYNC_STAGES'(bclk);
            lrck_sync_r <= (lrck_sync_r << 1) | SYNC_STAGES'(daclrck);
            bclk_d_r    <= bclk_s;
            ready_en_r  <= 1'b1;
        end
    end

    // Serializer FSM: every action is gated by a falling BCLK; an LRCK edge always restarts the slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ALIGN;
            ch_r         <= LEFT;
            lr_q_r       <= 1'b0;
            shreg_r      <= {DATA_W{1'b0}};
            hold_right_r <= {DATA_W{1'b0}};
            bitcnt_r     <= CNT_ZERO;
            dacdat_r     <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            if (bfall_s) begin
                lr_q_r <= lrck_s;
                if (state_r == ALIGN) begin
                    dacdat_r <= 1'b0;
                    if (lr_edge_s && (lrck_s == LEFT)) begin
                        state_r <= DELAY;
                        ch_r    <= LEFT;
                    end else begin
                        state_r <= ALIGN;
                    end
                end else if (lr_edge_s) begin
                    state_r  <= DELAY;
                    ch_r     <= lrck_s;
                    dacdat_r <= 1'b0;
                end else begin
                    case (state_r)
                        DELAY: begin
                            case (ch_r)
                                LEFT: begin
                                    if (fifo_empty_s) begin
                                        shreg_r      <= {DATA_W{1'b0}};
                                        hold_right_r <= {DATA_W{1'b0}};
                                        dacdat_r     <= 1'b0;
                                        underrun_r   <= 1'b1;
                                    end else begin
                                        shreg_r      <= fifo_rdata_s[2*DATA_W-1 -: DATA_W];
                                        hold_right_r <= fifo_rdata_s[DATA_W-1:0];
                                        dacdat_r     <= fifo_rdata_s[2*DATA_W-1];
                                    end
                                end
                                RIGHT: begin
                                    shreg_r  <= hold_right_r;
                                    dacdat_r <= hold_right_r[DATA_W-1];
                                end
                                default: begin
                                    shreg_r  <= {DATA_W{1'b0}};
                                    dacdat_r <= 1'b0;
                                end
                            endcase
                            bitcnt_r <= CNT_LAST;
                            state_r  <= SHIFT;
                        end
                        SHIFT: begin
                            shreg_r  <= {shreg_r[DATA_W-2:0], 1'b0};
                            dacdat_r <= shreg_r[DATA_W-2];
                            bitcnt_r <= bitcnt_r - CNT_ONE;
                            if (bitcnt_r <= CNT_ONE) begin
                                state_r <= PAD;
                            end else begin
                                state_r <= SHIFT;
                            end
                        end
                        PAD: begin
                            dacdat_r <= 1'b0;
                        end
                        default: begin
                            state_r  <= ALIGN;
                            dacdat_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomized bench for i2s_dac_tx: drives BCLK/DACLRCK frames as the codec would
// and compares each slot's sampled DACDAT bits with a queue-based frame model.
module tb_i2s_dac_tx;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        bclk;
    logic        daclrck;
    logic        dacdat;
    logic        underrun;
    logic [2:0]  fifo_level;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          under_cnt = 0;
    logic [31:0] model_q[$];
    bit          locked;
    bit          prev_lr;

    always #10 clk = ~clk;

    i2s_dac_tx #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .daclrck      (daclrck),
        .dacdat       (dacdat),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always @(negedge clk) begin
        if (underrun === 1'b1) under_cnt++;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit expected in cycle j of a slot: cycle 0 is the I2S delay, then MSB first, then padding.
    function automatic logic exp_bit(input logic [15:0] w, input int j);
        if (j >= 1 && j <= DATA_W) return w[DATA_W - j];
        return 1'b0;
    endfunction

    task automatic bclk_cycle(input bit lr, output bit d);
        bclk    = 1'b0;
        daclrck = lr;
        prev_lr = lr;
        repeat (HALF) @(negedge clk);
        d    = dacdat;
        bclk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_slot(input bit ch, input int len, input logic [15:0] w,
                            input bit active, input string tag);
        logic [63:0] got = 64'd0;
        logic [63:0] exp = 64'd0;
        bit d;
        for (int j = 0; j < len; j++) begin
            bclk_cycle(ch, d);
            got = {got[62:0], d};
            exp = {exp[62:0], (active ? exp_bit(w, j) : 1'b0)};
        end
        check_val(tag, got, exp);
    endtask

    task automatic run_frame(input int len);
        logic [31:0] pair = 32'd0;
        bit und = 1'b0;
        int cnt0;
        if (!locked && prev_lr) locked = 1'b1;
        if (locked) begin
            if (model_q.size() > 0) pair = model_q.pop_front();
            else und = 1'b1;
        end
        cnt0 = under_cnt;
        run_slot(1'b0, len, pair[31:16], locked, "left_bits");
        run_slot(1'b1, len, pair[15:0],  locked, "right_bits");
        check_val("underrun_pulses", under_cnt - cnt0, und);
        check_val("fifo_level", fifo_level, model_q.size());
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int waited = 0;
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        while (!sample_ready && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        if (sample_ready) begin
            @(negedge clk);
            model_q.push_back({l, r});
        end else begin
            check_val("push_timeout", sample_ready, 1'b1);
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        bit d;
        int dly;
        logic [31:0] pair;
        logic [63:0] got;
        logic [63:0] exp;

        reset_n = 1'b0; bclk = 1'b1; daclrck = 1'b1; sample_valid = 1'b0;
        sample_left = 16'd0; sample_right = 16'd0;
        locked = 1'b0; prev_lr = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_ready_low", sample_ready, 1'b0);
        check_val("rst_dacdat", dacdat, 1'b0);
        check_val("rst_level", fifo_level, 3'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", sample_ready, 1'b1);
        check_val("post_rst_dacdat", dacdat, 1'b0);
        check_val("post_rst_level", fifo_level, 3'd0);
        check_val("post_rst_underrun", underrun, 1'b0);

        // Idle: BCLK running, LRCK constant high; output must stay 0 and nothing pops.
        run_slot(1'b1, 40, 16'h0000, 1'b0, "idle_bits");
        check_val("idle_underrun", under_cnt, 0);

        // Single frame with the reference words.
        push_pair(16'hA5C3, 16'h0F01);
        check_val("single_level", fifo_level, 3'd1);
        run_frame(32);

        // Underrun, then recovery.
        run_frame(32);
        push_pair(16'h8000, 16'h7FFF);
        run_frame(32);

        // Backpressure: fill with no BCLK, then drain while a fifth pair waits.
        for (int k = 0; k < FIFO_DEPTH; k++) push_pair(16'($urandom), 16'($urandom));
        check_val("full_ready", sample_ready, 1'b0);
        check_val("full_level", fifo_level, 3'd4);
        fork
            push_pair(16'($urandom), 16'($urandom));
            run_frame(32);
        join
        for (int k = 0; k < FIFO_DEPTH; k++) run_frame(32);

        // Pushes swept across the pop clock so one lands on the same clk as the pop.
        push_pair(16'($urandom), 16'($urandom));
        for (int o = 0; o < 6; o++) begin
            dly = 2 * HALF + o;
            fork
                run_frame(32);
                begin
                    repeat (dly) @(negedge clk);
                    push_pair(16'($urandom), 16'($urandom));
                end
            join
        end
        while (model_q.size() > 0) run_frame(20);

        // Short slots truncate the word; the following frame must start cleanly.
        push_pair(16'hFFFF, 16'hFFFF);
        push_pair(16'h8001, 16'h4002);
        run_frame(12);
        run_frame(32);

        // Random words and slot lengths.
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                if (model_q.size() < FIFO_DEPTH) push_pair(16'($urandom), 16'($urandom));
            end
            run_frame($urandom_range(4, 32));
        end

        // Reset while bit 7 of a left word is on the wire.
        while (model_q.size() < 2) push_pair(16'($urandom), 16'($urandom));
        pair = model_q.pop_front();
        got = 64'd0; exp = 64'd0;
        for (int j = 0; j < 10; j++) begin
            bclk_cycle(1'b0, d);
            got = {got[62:0], d};
            exp = {exp[62:0], exp_bit(pair[31:16], j)};
        end
        check_val("pre_reset_bits", got, exp);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("reset_dacdat", dacdat, 1'b0);
        repeat (2) @(negedge clk);
        check_val("reset_fifo_cleared", fifo_level, 3'd0);
        reset_n = 1'b1;
        model_q.delete();
        locked = 1'b0; prev_lr = 1'b0;
        @(negedge clk);
        check_val("rerst_ready", sample_ready, 1'b1);
        run_slot(1'b0, 20, 16'h0000, 1'b0, "align_left");
        run_slot(1'b1, 32, 16'h0000, 1'b0, "align_right");
        push_pair(16'($urandom), 16'($urandom));
        run_frame(32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
